// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a shared combinational ALU.
// Optional illegal-opcode screening is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [3:0]       req1_op,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_port,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;
    localparam logic [3:0] OP_ADD = 4'd15;

    state_t           state;
    logic             last;      // port granted most recently
    logic             cur_port;  // port owning the in-flight operation
    logic             any_valid;
    logic             grant;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [3:0]       sel_op;

`ifdef ALU_ARB_OPCHECK_EN
    logic op_err;

    function automatic logic op_legal(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_SUB, OP_SLT, OP_NOR, OP_ADD};
    endfunction
`endif

    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        any_valid = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign sel_x  = grant ? req1_x  : req0_x;
    assign sel_y  = grant ? req1_y  : req0_y;
    assign sel_op = grant ? req1_op : req0_op;

    // Ready is a function of valid; requesters must not wait for ready before raising valid.
    assign req0_ready = (state == IDLE) & any_valid & ~grant;
    assign req1_ready = (state == IDLE) & any_valid &  grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            cur_port  <= 1'b0;
            alu_x     <= '0;
            alu_y     <= '0;
            alu_op    <= OP_AND;
            rsp_valid <= 1'b0;
            rsp_port  <= 1'b0;
            rsp_r     <= '0;
            rsp_zero  <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
            op_err    <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_x    <= sel_x;
                        alu_y    <= sel_y;
                        cur_port <= grant;
                        last     <= grant;
                        state    <= EXEC;
`ifdef ALU_ARB_OPCHECK_EN
                        // Illegal opcodes run as a harmless AND; the result is discarded in EXEC.
                        alu_op   <= op_legal(sel_op) ? sel_op : OP_AND;
                        op_err   <= ~op_legal(sel_op);
`else
                        alu_op   <= sel_op;
`endif
                    end
                end
                EXEC: begin
                    rsp_port  <= cur_port;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`ifdef ALU_ARB_OPCHECK_EN
                    rsp_r     <= op_err ? '0 : alu_r;
                    rsp_zero  <= op_err | alu_zero;
                    rsp_err   <= op_err;
`else
                    rsp_r     <= alu_r;
                    rsp_zero  <= alu_zero;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifndef ALU_ARB_OPCHECK_EN
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU, a transaction-level
// arbitration model and directed/random request sequences.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_x, alu_y, alu_r;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_port, rsp_zero, rsp_err;
    logic [31:0] rsp_r;

    logic        rq_v  [2];
    logic [31:0] rq_x  [2];
    logic [31:0] rq_y  [2];
    logic [3:0]  rq_op [2];
    logic        m_last;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  legal_ops [6] = '{4'd0, 4'd1, 4'd15, 4'd6, 4'd7, 4'd12};

    always #5 clk = ~clk;

    assign req0_valid = rq_v[0];
    assign req0_x     = rq_x[0];
    assign req0_y     = rq_y[0];
    assign req0_op    = rq_op[0];
    assign req1_valid = rq_v[1];
    assign req1_x     = rq_x[1];
    assign req1_y     = rq_y[1];
    assign req1_op    = rq_op[1];

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
        .rsp_r(rsp_r), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Behaviour of the shared ALU; opcodes outside the legal set produce x^y.
    function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                           input logic [3:0] op);
        case (op)
            4'd0:    return x & y;
            4'd1:    return x | y;
            4'd15:   return x + y;
            4'd6:    return x - y;
            4'd7:    return (x < y) ? 32'd1 : 32'd0;
            4'd12:   return ~(x | y);
            default: return x ^ y;
        endcase
    endfunction

    always_comb begin
        alu_r    = alu_fn(alu_x, alu_y, alu_op);
        alu_zero = (alu_r == 32'd0);
    end

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd15, 4'd6, 4'd7, 4'd12};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_req(input int p, input bit legal_only);
        rq_x[p] = $urandom;
        rq_y[p] = ($urandom_range(0, 3) == 0) ? rq_x[p] : $urandom;
        rq_op[p] = legal_only ? legal_ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
        rq_v[p] = 1'b1;
    endtask

    task automatic set_req(input int p, input logic [31:0] x, input logic [31:0] y,
                           input logic [3:0] op);
        rq_x[p] = x; rq_y[p] = y; rq_op[p] = op; rq_v[p] = 1'b1;
    endtask

    task automatic check_rsp(input int p, input logic [31:0] ex, input logic [31:0] er,
                             input logic ez, input logic ee);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_port", 32'(rsp_port), 32'(p));
        check("rsp_r", rsp_r, er);
        check("rsp_zero", 32'(rsp_zero), 32'(ez));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("resp_ready0", 32'(req0_ready), 32'd0);
        check("resp_ready1", 32'(req1_ready), 32'd0);
        check("resp_alu_x", alu_x, ex);
    endtask

    // Runs one operation from IDLE (entered just after a rising edge, requests set)
    // through the response handshake; hold = cycles rsp_ready is withheld in RESP.
    task automatic serve(input int hold, input bit refill);
        int          p;
        logic [31:0] ex, ey, er;
        logic [3:0]  eop, aop;
        logic        ez, ee;
        p   = (rq_v[0] && rq_v[1]) ? (m_last ? 0 : 1) : (rq_v[1] ? 1 : 0);
        ex  = rq_x[p];
        ey  = rq_y[p];
        eop = rq_op[p];
`ifdef ALU_ARB_OPCHECK_EN
        ee  = !is_legal(eop);
`else
        ee  = 1'b0;
`endif
        aop = ee ? 4'd0 : eop;
        er  = ee ? 32'd0 : alu_fn(ex, ey, eop);
        ez  = (er == 32'd0);

        @(negedge clk);
        check("idle_ready0", 32'(req0_ready), 32'(p == 0));
        check("idle_ready1", 32'(req1_ready), 32'(p == 1));
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        m_last = p[0];
        if (refill) rand_req(p, 1'b1);
        else rq_v[p] = 1'b0;
        @(negedge clk);
        check("exec_alu_x", alu_x, ex);
        check("exec_alu_y", alu_y, ey);
        check("exec_alu_op", 32'(alu_op), 32'(aop));
        check("exec_ready0", 32'(req0_ready), 32'd0);
        check("exec_ready1", 32'(req1_ready), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_rsp(p, ex, er, ez, ee);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_rsp(p, ex, er, ez, ee);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        m_last    = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rq_v[p] = 1'b0; rq_x[p] = '0; rq_y[p] = '0; rq_op[p] = '0;
        end
        #12;
        check("rst_alu_x", alu_x, 32'd0);
        check("rst_alu_y", alu_y, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_port", 32'(rsp_port), 32'd0);
        check("rst_rsp_r", rsp_r, 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations from the plan.
        set_req(0, 32'd5, 32'd3, 4'd15);
        serve(0, 1'b0);
        check("add_result_const", rsp_r, 32'd8);
        set_req(1, 32'd7, 32'd7, 4'd6);
        serve(0, 1'b0);
        set_req(0, 32'hFFFF_FFFF, 32'd1, 4'd7);
        serve(0, 1'b0);
        set_req(1, 32'h1234_5678, 32'h0F0F_0F0F, 4'd3);
        serve(1, 1'b0);

        // Continuous contention: grants alternate, interval 3 cycles.
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        for (int k = 0; k < 8; k++) serve(0, 1'b1);
        rq_v[0] = 1'b0;
        rq_v[1] = 1'b0;

        // Response held with requests pending on both ports.
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        serve(5, 1'b0);
        serve(0, 1'b0);

        // rsp_ready while idle is ignored.
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_ready_ignored", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Random mixes of ports, opcodes and hold times.
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 2))
                0:       rand_req(0, 1'b0);
                1:       rand_req(1, 1'b0);
                default: begin rand_req(0, 1'b0); rand_req(1, 1'b0); end
            endcase
            serve($urandom_range(0, 2), 1'b0);
            rq_v[0] = 1'b0;
            rq_v[1] = 1'b0;
        end

        // Reset during EXEC drops the operation.
        set_req(1, 32'd9, 32'd4, 4'd15);
        @(posedge clk); #1;
        rq_v[1] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_alu_x", alu_x, 32'd0);
        check("rst_exec_rsp_r", rsp_r, 32'd0);
        m_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        serve(0, 1'b0);
        serve(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between two requesters, such as a datapath issue stage and a debug/test port. It accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. One cycle later it captures the ALU result and zero flag into a response register. The response is held until the consumer accepts it, and it is tagged with the originating port.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req0_valid`  in  1  port 0 request valid.
- `req0_ready`  out  1  port 0 accepted this cycle.
- `req0_x`, `req0_y`  in  WIDTH  port 0 operands.
- `req0_op`  in  4  port 0 opcode.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_y`, `req1_op`  same for port 1.
- `alu_x`, `alu_y`  out  WIDTH  registered operands to the ALU.
- `alu_op`  out  4  registered opcode to the ALU.
- `alu_r`  in  WIDTH  ALU result (combinational from `alu_x`/`alu_y`/`alu_op`).
- `alu_zero`  in  1  ALU zero flag.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_port`  out  1  originating port (0/1).
- `rsp_r`  out  WIDTH  captured result.
- `rsp_zero`  out  1  captured zero flag.
- `rsp_err`  out  1  illegal opcode flag (see Configuration).

## Operation
- Legal opcodes:
  - 0 = AND
  - 1 = OR
  - 15 = ADD
  - 6 = SUB
  - 7 = SLT (unsigned compare, result 0/1)
  - 12 = NOR
- All other opcode values are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed from valids.
  - If only one port is valid, that port is granted.
  - If both are valid, the port not served last is granted (`last` register).
  - `reqN_ready` = (state==IDLE) & grant==N. Ready depends combinationally on valid, so requesters must not make valid depend on ready.
  - On accept: load `alu_x`/`alu_y`/`alu_op` from the granted port, record the port, set `last` to the granted port, then go to EXEC.
- EXEC:
  - Capture `alu_r` into `rsp_r` and `alu_zero` into `rsp_zero`.
  - Set `rsp_port` and `rsp_err`, then go to RESP.
  - Both readys are 0.
- RESP:
  - `rsp_valid`=1. Response outputs and ALU inputs are held stable.
  - On `rsp_ready`=1, go to IDLE.
  - Both readys are 0. No new request is accepted in the same cycle as the response handshake.
- `alu_x`/`alu_y`/`alu_op` change only on accept. Between operations they keep their last values.
- Reset values:
  - state IDLE, `last`=1 (port 0 wins the first tie).
  - `alu_x`/`alu_y`=0, `alu_op`=0.
  - `rsp_valid`=0, `rsp_port`=0, `rsp_r`=0, `rsp_zero`=0, `rsp_err`=0.
  - `req0_ready`/`req1_ready` follow IDLE rules.
- Reset asserted mid-operation: immediate return to reset values. The in-flight operation is dropped with no response.
- `rsp_ready` asserted outside RESP is ignored.

## Timing
- Accept at edge N (valid & ready high). `alu_*` are updated after edge N. `rsp_valid` rises after edge N+1.
- Minimum initiation interval is 3 cycles per operation (IDLE, EXEC, RESP with immediate `rsp_ready`).
- The ALU path is one full cycle: registered inputs, combinational ALU, response register.
- `rsp_valid` stays high and all `rsp_*` stay stable until the cycle in which `rsp_ready`=1.
- Under continuous contention from both ports, grants alternate strictly 0,1,0,1.

## Configuration
- `ALU_ARB_OPCHECK_EN` defined:
  - An illegal opcode is still accepted and still sequences IDLE→EXEC→RESP.
  - `alu_op` is loaded with 0 (AND) instead of the illegal value.
  - In the response: `rsp_err`=1, `rsp_r`=0, `rsp_zero`=1.
- Undefined:
  - The opcode passes through unchecked and `rsp_err` is tied to 0.
  - `rsp_r`/`rsp_zero` are whatever the ALU presents for that opcode.

## Test plan
- Reset, then port 0 requests x=5, y=3, op=15 -> ready pulse at acceptance; `rsp_valid` two cycles later with `rsp_r`=8, `rsp_zero`=0, `rsp_port`=0.
- Port 1 requests SUB x=7, y=7 -> `rsp_r`=0, `rsp_zero`=1, `rsp_port`=1.
- Both ports valid continuously with distinct ops, `rsp_ready`=1 -> service order 0,1,0,1; each response matches its port's operands; 3-cycle interval.
- Response held with `rsp_ready`=0 for 5 cycles, new requests pending -> `rsp_*` stable, both readys 0; accepted request follows only after the handshake.
- SLT x=32'hFFFFFFFF, y=1 -> `rsp_r`=0 (unsigned); op=4'd3 with `ALU_ARB_OPCHECK_EN` -> `rsp_err`=1, `rsp_r`=0.
- `rst_n` low during EXEC -> `rsp_valid`=0 immediately, no response after release, next request served normally from port 0 on tie.
